// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared constants and types for the fetch stage
package fetch_pkg;

  localparam int PC_W_DEF  = 16;
  localparam int INS_W_DEF = 32;

  // Opcode occupies ins[INS_W-OP_MSB_OFS : INS_W-OP_LSB_OFS]
  localparam int OP_MSB_OFS = 1;
  localparam int OP_LSB_OFS = 6;
  localparam int OP_W       = OP_LSB_OFS - OP_MSB_OFS + 1;

  localparam logic [INS_W_DEF-1:0] NOP_INS = '0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - fetch stage control, program-memory and decode-side signals
interface instr_fetch_unit_if #(
  parameter int PC_W  = 16,
  parameter int INS_W = 32
);
  logic             stall;
  logic             stall_pm;
  logic             jmp_en;
  logic [PC_W-1:0]  jmp_addr;
  logic [PC_W-1:0]  pm_addr;
  logic [INS_W-1:0] pm_rdata;
  logic [INS_W-1:0] ins_out;
  logic [5:0]       op_out;
  logic [PC_W-1:0]  pc_out;
  logic             ins_valid;
`ifdef FETCH_STALL_CNT_EN
  logic [15:0]      stall_cnt;
`endif

  modport master (
    input  stall, stall_pm, jmp_en, jmp_addr, pm_rdata,
`ifdef FETCH_STALL_CNT_EN
    output stall_cnt,
`endif
    output pm_addr, ins_out, op_out, pc_out, ins_valid
  );

  modport slave (
    output stall, stall_pm, jmp_en, jmp_addr, pm_rdata,
`ifdef FETCH_STALL_CNT_EN
    input  stall_cnt,
`endif
    input  pm_addr, ins_out, op_out, pc_out, ins_valid
  );
endinterface

// File: rtl/instr_fetch_unit_pc_reg.sv
// rtl/instr_fetch_unit_pc_reg.sv - program counter with load, hold and wrapping increment
module pc_reg #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [PC_W-1:0] load_addr,
  input  logic            hold,
  output logic [PC_W-1:0] pc
);

  // Load beats hold beats increment; the add naturally wraps modulo 2^PC_W
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pc <= RESET_PC;
    else if (load)
      pc <= load_addr;
    else if (!hold)
      pc <= pc + 1'b1;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage: PC, instruction register, bubble/flush control (optional FETCH_STALL_CNT_EN)
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              INS_W    = INS_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic         clk,
  input logic         reset,
  instr_fetch_unit_if.master bus
);

  localparam logic [1:0] ST_RUN   = RUN;
  localparam logic [1:0] ST_HOLD  = HOLD;
  localparam logic [1:0] ST_FLUSH = FLUSH;

  logic [PC_W-1:0]  pc_q;
  logic [INS_W-1:0] ins_q;
  logic [PC_W-1:0]  pc_out_q;
  logic             valid_q;
  logic [1:0]       state;

  pc_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (bus.jmp_en),
    .load_addr (bus.jmp_addr),
    .hold      (bus.stall),
    .pc        (pc_q)
  );

  // IR update and state tracking: jump > bubble > hold > normal fetch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ins_q    <= INS_W'(NOP_INS);
      pc_out_q <= '0;
      valid_q  <= 1'b0;
      state    <= ST_FLUSH;
    end else if (bus.jmp_en) begin
      ins_q   <= INS_W'(NOP_INS);
      valid_q <= 1'b0;
      state   <= ST_FLUSH;
    end else if (bus.stall_pm) begin
      ins_q   <= INS_W'(NOP_INS);
      valid_q <= 1'b0;
      state   <= ST_HOLD;
    end else if (bus.stall) begin
      // A hold straight out of FLUSH must keep reporting the bubble as invalid
      valid_q <= (state == ST_FLUSH) ? 1'b0 : valid_q;
      state   <= ST_HOLD;
    end else begin
      ins_q    <= bus.pm_rdata;
      pc_out_q <= pc_q;
      valid_q  <= 1'b1;
      state    <= ST_RUN;
    end
  end

  assign bus.pm_addr   = pc_q;
  assign bus.ins_out   = ins_q;
  assign bus.op_out    = ins_q[INS_W-OP_MSB_OFS : INS_W-OP_LSB_OFS];
  assign bus.pc_out    = pc_out_q;
  assign bus.ins_valid = valid_q;

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of edges on which the stall block held or bubbled fetch
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cnt_q <= '0;
    else if ((bus.stall || bus.stall_pm) && !bus.jmp_en && (stall_cnt_q != 16'hFFFF))
      stall_cnt_q <= stall_cnt_q + 16'd1;
  end

  assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int cnt_exp = 0;

  instr_fetch_unit_if #(.PC_W(16), .INS_W(32)) bus ();

  instr_fetch_unit #(.PC_W(16), .INS_W(32), .RESET_PC(16'h0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: mem_word = 32'h11111111;
      16'h0001: mem_word = 32'h22222222;
      16'h0002: mem_word = 32'h33333333;
      16'h0003: mem_word = 32'h44444444;
      16'h0040: mem_word = 32'hFC000040;
      16'hFFFF: mem_word = 32'hDEADBEEF;
      default:  mem_word = {16'hC0DE, a};
    endcase
  endfunction

  always_comb bus.pm_rdata = mem_word(bus.pm_addr);

  task automatic step();
    if ((bus.stall || bus.stall_pm) && !bus.jmp_en && !reset && cnt_exp < 65535) cnt_exp++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.stall = 0; bus.stall_pm = 0; bus.jmp_en = 0; bus.jmp_addr = 16'h0;
    reset = 1;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (bus.pm_addr !== 16'h0000) begin errors++; $display("FAIL reset_pm_addr got %h exp %h", bus.pm_addr, 16'h0); end
    checks++; if (bus.ins_out !== 32'h0) begin errors++; $display("FAIL reset_ins got %h exp %h", bus.ins_out, 32'h0); end
    checks++; if (bus.ins_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.ins_valid); end
    checks++; if (bus.pc_out !== 16'h0) begin errors++; $display("FAIL reset_pc_out got %h exp 0000", bus.pc_out); end
    checks++; if (bus.op_out !== 6'h0) begin errors++; $display("FAIL reset_op got %h exp 00", bus.op_out); end
`ifdef FETCH_STALL_CNT_EN
    checks++; if (bus.stall_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt got %h exp 0000", bus.stall_cnt); end
`endif
    reset = 0;
    cnt_exp = 0;
  endtask

  task automatic test_sequential();
    step();
    checks++; if (bus.ins_out !== 32'h11111111) begin errors++; $display("FAIL seq0_ins got %h exp 11111111", bus.ins_out); end
    checks++; if (bus.pc_out !== 16'h0000) begin errors++; $display("FAIL seq0_pc got %h exp 0000", bus.pc_out); end
    checks++; if (bus.ins_valid !== 1'b1) begin errors++; $display("FAIL seq0_valid got %b exp 1", bus.ins_valid); end
    step();
    checks++; if (bus.ins_out !== 32'h22222222) begin errors++; $display("FAIL seq1_ins got %h exp 22222222", bus.ins_out); end
    checks++; if (bus.pc_out !== 16'h0001) begin errors++; $display("FAIL seq1_pc got %h exp 0001", bus.pc_out); end
    step();
    checks++; if (bus.ins_out !== 32'h33333333) begin errors++; $display("FAIL seq2_ins got %h exp 33333333", bus.ins_out); end
    checks++; if (bus.pc_out !== 16'h0002) begin errors++; $display("FAIL seq2_pc got %h exp 0002", bus.pc_out); end
    checks++; if (bus.pm_addr !== 16'h0003) begin errors++; $display("FAIL seq2_pm_addr got %h exp 0003", bus.pm_addr); end
  endtask

  task automatic test_stall_hold();
    bus.stall = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (bus.pm_addr !== 16'h0003) begin errors++; $display("FAIL hold%0d_pm_addr got %h exp 0003", i, bus.pm_addr); end
      checks++; if (bus.ins_out !== 32'h33333333) begin errors++; $display("FAIL hold%0d_ins got %h exp 33333333", i, bus.ins_out); end
      checks++; if (bus.pc_out !== 16'h0002) begin errors++; $display("FAIL hold%0d_pc got %h exp 0002", i, bus.pc_out); end
      checks++; if (bus.ins_valid !== 1'b1) begin errors++; $display("FAIL hold%0d_valid got %b exp 1", i, bus.ins_valid); end
    end
    bus.stall = 0;
    step();
    checks++; if (bus.ins_out !== 32'h44444444) begin errors++; $display("FAIL release_ins got %h exp 44444444", bus.ins_out); end
    checks++; if (bus.pc_out !== 16'h0003) begin errors++; $display("FAIL release_pc got %h exp 0003", bus.pc_out); end
  endtask

  task automatic test_bubble();
    bus.stall = 1; bus.stall_pm = 1;
    step();
    checks++; if (bus.ins_out !== 32'h0) begin errors++; $display("FAIL bubble_ins got %h exp 00000000", bus.ins_out); end
    checks++; if (bus.op_out !== 6'h00) begin errors++; $display("FAIL bubble_op got %h exp 00", bus.op_out); end
    checks++; if (bus.ins_valid !== 1'b0) begin errors++; $display("FAIL bubble_valid got %b exp 0", bus.ins_valid); end
    checks++; if (bus.pm_addr !== 16'h0004) begin errors++; $display("FAIL bubble_pm_addr got %h exp 0004", bus.pm_addr); end
    bus.stall = 0; bus.stall_pm = 0;
    step();
    checks++; if (bus.ins_out !== 32'hC0DE0004) begin errors++; $display("FAIL after_bubble_ins got %h exp C0DE0004", bus.ins_out); end
    checks++; if (bus.op_out !== 6'h30) begin errors++; $display("FAIL after_bubble_op got %h exp 30", bus.op_out); end
    checks++; if (bus.pc_out !== 16'h0004) begin errors++; $display("FAIL after_bubble_pc got %h exp 0004", bus.pc_out); end
  endtask

  task automatic test_jump();
    bus.jmp_en = 1; bus.jmp_addr = 16'h0040; bus.stall = 1;
    step();
    checks++; if (bus.pm_addr !== 16'h0040) begin errors++; $display("FAIL jump_pm_addr got %h exp 0040", bus.pm_addr); end
    checks++; if (bus.ins_out !== 32'h0) begin errors++; $display("FAIL jump_ins got %h exp 00000000", bus.ins_out); end
    checks++; if (bus.ins_valid !== 1'b0) begin errors++; $display("FAIL jump_valid got %b exp 0", bus.ins_valid); end
    bus.jmp_en = 0; bus.stall = 0;
    step();
    checks++; if (bus.ins_out !== 32'hFC000040) begin errors++; $display("FAIL jump_tgt_ins got %h exp FC000040", bus.ins_out); end
    checks++; if (bus.op_out !== 6'h3F) begin errors++; $display("FAIL jump_tgt_op got %h exp 3F", bus.op_out); end
    checks++; if (bus.pc_out !== 16'h0040) begin errors++; $display("FAIL jump_tgt_pc got %h exp 0040", bus.pc_out); end
    checks++; if (bus.pm_addr !== 16'h0041) begin errors++; $display("FAIL jump_tgt_pm_addr got %h exp 0041", bus.pm_addr); end
  endtask

  task automatic test_wrap();
    bus.jmp_en = 1; bus.jmp_addr = 16'hFFFF;
    step();
    checks++; if (bus.pm_addr !== 16'hFFFF) begin errors++; $display("FAIL wrap_pm_addr got %h exp FFFF", bus.pm_addr); end
    bus.jmp_en = 0;
    step();
    checks++; if (bus.ins_out !== 32'hDEADBEEF) begin errors++; $display("FAIL wrap_ins got %h exp DEADBEEF", bus.ins_out); end
    checks++; if (bus.op_out !== 6'h37) begin errors++; $display("FAIL wrap_op got %h exp 37", bus.op_out); end
    checks++; if (bus.pc_out !== 16'hFFFF) begin errors++; $display("FAIL wrap_pc got %h exp FFFF", bus.pc_out); end
    checks++; if (bus.pm_addr !== 16'h0000) begin errors++; $display("FAIL wrap_next_pm_addr got %h exp 0000", bus.pm_addr); end
    step();
    checks++; if (bus.ins_out !== 32'h11111111) begin errors++; $display("FAIL wrap_after_ins got %h exp 11111111", bus.ins_out); end
  endtask

  task automatic test_stall_pm_only();
    bus.stall_pm = 1;
    step();
    checks++; if (bus.pm_addr !== 16'h0002) begin errors++; $display("FAIL pm_only_pm_addr got %h exp 0002", bus.pm_addr); end
    checks++; if (bus.ins_valid !== 1'b0) begin errors++; $display("FAIL pm_only_valid got %b exp 0", bus.ins_valid); end
    bus.stall_pm = 0;
    step();
    checks++; if (bus.ins_out !== 32'h33333333) begin errors++; $display("FAIL pm_only_next_ins got %h exp 33333333", bus.ins_out); end
    checks++; if (bus.pc_out !== 16'h0002) begin errors++; $display("FAIL pm_only_next_pc got %h exp 0002", bus.pc_out); end
  endtask

  task automatic test_async_reset();
    bus.stall = 1;
    step();
    step();
`ifdef FETCH_STALL_CNT_EN
    checks++; if (bus.stall_cnt !== 16'(cnt_exp)) begin errors++; $display("FAIL cnt_before_reset got %h exp %h", bus.stall_cnt, 16'(cnt_exp)); end
`endif
    #2 reset = 1;
    #1;
    checks++; if (bus.pm_addr !== 16'h0000) begin errors++; $display("FAIL areset_pm_addr got %h exp 0000", bus.pm_addr); end
    checks++; if (bus.ins_out !== 32'h0) begin errors++; $display("FAIL areset_ins got %h exp 00000000", bus.ins_out); end
    checks++; if (bus.ins_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b exp 0", bus.ins_valid); end
    checks++; if (bus.pc_out !== 16'h0000) begin errors++; $display("FAIL areset_pc got %h exp 0000", bus.pc_out); end
`ifdef FETCH_STALL_CNT_EN
    checks++; if (bus.stall_cnt !== 16'h0) begin errors++; $display("FAIL areset_cnt got %h exp 0000", bus.stall_cnt); end
`endif
    #1 reset = 0;
    cnt_exp = 0;
    bus.stall = 0;
    step();
    checks++; if (bus.ins_out !== 32'h11111111) begin errors++; $display("FAIL post_reset_ins got %h exp 11111111", bus.ins_out); end
    checks++; if (bus.ins_valid !== 1'b1) begin errors++; $display("FAIL post_reset_valid got %b exp 1", bus.ins_valid); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall_hold();
    test_bubble();
    test_jump();
    test_wrap();
    test_stall_pm_only();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of Stall_Control_Block.
- Holds the PC and drives the program-memory address. Registers the fetched word into the instruction register (IR) and presents the opcode field to the stall block.
- Consumes stall/stall_pm back from the stall block to hold the PC and insert bubbles. Handles jump redirect with a one-cycle flush.

Parameters:
- PC_W, 16, PC / program-memory address width.
- INS_W, 32, instruction width; opcode = ins[INS_W-1:INS_W-6].
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  from stall block: hold PC.
- stall_pm  in  1  from stall block: load NOP into IR instead of memory data.
- jmp_en  in  1  redirect request from execute stage.
- jmp_addr  in  PC_W  redirect target.
- pm_addr  out  PC_W  program-memory address (combinational = pc_q).
- pm_rdata  in  INS_W  program-memory read data (combinational read, same cycle).
- ins_out  out  INS_W  IR contents to decode.
- op_out  out  6  ins_out[INS_W-1:INS_W-6], feeds stall block op.
- pc_out  out  PC_W  address of the instruction currently in IR.
- ins_valid  out  1  IR holds a real (non-bubble) instruction.

Behaviour:
- Reset (async, any time): pc_q=RESET_PC, IR=NOP (all zeros), pc_out=0, ins_valid=0, state=FLUSH. Effect is immediate; mid-operation reset discards the IR.
- FSM states: RUN, HOLD, FLUSH. Per clock edge, priority is jmp_en > stall_pm > stall > normal.
- jmp_en=1:
  - pc_q<=jmp_addr; IR<=NOP; ins_valid<=0; state->FLUSH.
  - stall/stall_pm are ignored this cycle.
- stall_pm=1 (jmp_en=0):
  - IR<=NOP; ins_valid<=0.
  - PC holds if stall=1, else pc_q<=pc_q+1.
  - state->HOLD.
- stall=1, stall_pm=0: PC holds, IR holds (incl. ins_valid, pc_out); state->HOLD.
- Normal: IR<=pm_rdata; pc_out<=pc_q; ins_valid<=1; pc_q<=pc_q+1; state->RUN.
- FLUSH: lasts exactly one cycle after reset or jump; the next edge follows the normal rules. In FLUSH, ins_valid=0 even if the stall block asserts nothing.
- Latency: one cycle from pm_addr=A to ins_out=mem[A] when unstalled. Jump target appears in IR two edges after jmp_en is sampled.
- PC increment wraps modulo 2^PC_W: 0xFFFF+1 -> 0x0000, no flag.
- op_out is purely combinational from IR, so a NOP bubble presents op=000000 to the stall block, which terminates its stall sequence.
- No output is X after reset; all outputs are driven from registers except pm_addr and op_out.

Optional Feature:
- Macro: FETCH_STALL_CNT_EN.
- Defined: extra output stall_cnt[15:0]. Increments on every clock edge where stall|stall_pm=1 and jmp_en=0; saturates at 0xFFFF; cleared by reset.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package fetch_pkg holds:
  - NOP_INS constant;
  - opcode field MSB/LSB offsets;
  - fetch_state_t enum {RUN, HOLD, FLUSH};
  - PC_W/INS_W defaults.
- One natural sub-module: pc_reg. It is the PC register with load (jump), hold (stall) and increment, plus the wrap rule. The FSM and IR stay in the top.

Test Plan:
- Reset/sequential fetch: assert reset, release; mem[0..3]=0x11111111..0x44444444 -> after FLUSH, ins_out steps 0x11111111, 0x22222222, 0x33333333 on consecutive edges; pc_out=0,1,2; ins_valid=1.
- Stall hold: stall=1 for 2 cycles while pc_q=3 -> pm_addr stays 3, ins_out/pc_out unchanged; on release, ins_out=mem[3].
- Bubble: stall_pm=1, stall=1 for 1 cycle -> ins_out=0, op_out=000000, ins_valid=0, PC held; next cycle the same address is fetched.
- Jump: jmp_en=1, jmp_addr=0x0040 with stall=1 asserted simultaneously -> pm_addr=0x0040 next cycle, IR=NOP, state FLUSH; mem[0x40] in IR one edge later.
- Wrap: force pc to 0xFFFF via jump -> ins_out=mem[0xFFFF], next pm_addr=0x0000.
- Async reset mid-stall: reset pulse between edges while stall=1 -> outputs immediately RESET_PC/NOP/ins_valid=0; stall_cnt=0 (with FETCH_STALL_CNT_EN).
